// File: rtl/wb_regfile_if.sv
// Bundle of writeback-stage and register-read signals between the
// MEM/WB pipeline register, the ID stage and the register file.
// Signal names keep the register file's own _i/_o view, so the slave
// modport reads naturally from inside wb_regfile.
//
// Handshake: there is no valid/ready pair on this bus. RegWrite_i is a
// single-cycle qualifier: a writeback is offered every cycle it is high
// and is always accepted (the file never back-pressures). WBvalid_o
// reports whether the offered writeback actually commits (nonzero
// destination).
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic [DATA_W-1:0] Data_i;
    logic [DATA_W-1:0] ALUout_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] WBdata_o;
    logic              WBvalid_o;
    logic [31:0]       WBcount_o;

    // Register file side
    modport slave (
        input  RegWrite_i, MemtoReg_i, Data_i, ALUout_i,
        input  RDaddr_i, RSaddr_i, RTaddr_i,
        output RSdata_o, RTdata_o, WBdata_o, WBvalid_o, WBcount_o
    );

    // Pipeline / stimulus side
    modport master (
        output RegWrite_i, MemtoReg_i, Data_i, ALUout_i,
        output RDaddr_i, RSaddr_i, RTaddr_i,
        input  RSdata_o, RTdata_o, WBdata_o, WBvalid_o, WBcount_o
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects memory data or ALU result,
// commits it to a 32-entry GPR file (x0 hardwired to zero), serves two
// combinational read ports with optional same-cycle bypass, and counts
// committed writes. NREG must equal 2**ADDR_W.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic         clk_i,
    input logic         rst_i,
    wb_regfile_if.slave wb
);

    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic              rs_hit;
    logic              rt_hit;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [31:0]       wbcount_q;
    logic [31:0]       wbcount_d;

    // Writeback value select and commit qualifier (x0 writes are dropped)
    always_comb begin
        wb_data  = wb.MemtoReg_i ? wb.Data_i : wb.ALUout_i;
        wb_valid = wb.RegWrite_i && (wb.RDaddr_i != '0);
    end

    // Next register contents: only the addressed entry changes, so an
    // unknown RegWrite_i never disturbs other entries; entry 0 stays zero
    always_comb begin
        regs_d = regs_q;
        if (wb_valid) begin
            regs_d[wb.RDaddr_i] = wb_data;
        end
        regs_d[0] = '0;
    end

    // Commit counter, wraps naturally at 2**32
    always_comb begin
        wbcount_d = wb_valid ? wbcount_q + 32'd1 : wbcount_q;
    end

    // Register array and counter; asynchronous reset wins over any write
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wbcount_q <= '0;
        end else begin
            regs_q    <= regs_d;
            wbcount_q <= wbcount_d;
        end
    end

    // Read ports; bypass hits need wb_valid, so address 0 can never bypass
    always_comb begin
        rs_hit = (BYPASS != 0) && wb_valid && (wb.RSaddr_i == wb.RDaddr_i);
        rt_hit = (BYPASS != 0) && wb_valid && (wb.RTaddr_i == wb.RDaddr_i);
        wb.RSdata_o = rs_hit ? wb_data : regs_q[wb.RSaddr_i];
        wb.RTdata_o = rt_hit ? wb_data : regs_q[wb.RTaddr_i];
    end

    // Forwarding-unit and status outputs
    always_comb begin
        wb.WBdata_o  = wb_data;
        wb.WBvalid_o = wb_valid;
        wb.WBcount_o = wbcount_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one instance with bypass, one without,
// both driven by the same stimulus. Inputs change on the falling edge,
// outputs are sampled 1ns later, commits happen on the rising edge.
module tb_wb_regfile;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

  wb_regfile #(.DATA_W(32), .NREG(32), .ADDR_W(5), .BYPASS(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .wb    (if_b)
  );

  wb_regfile #(.DATA_W(32), .NREG(32), .ADDR_W(5), .BYPASS(0)) dut_n (
    .clk_i (clk),
    .rst_i (rst_n),
    .wb    (if_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks (both instances see identical stimulus)
  task automatic drive_wr(input logic we, input logic m2r, input logic [31:0] data,
                          input logic [31:0] alu, input logic [4:0] rd);
    if_b.RegWrite_i = we;   if_n.RegWrite_i = we;
    if_b.MemtoReg_i = m2r;  if_n.MemtoReg_i = m2r;
    if_b.Data_i     = data; if_n.Data_i     = data;
    if_b.ALUout_i   = alu;  if_n.ALUout_i   = alu;
    if_b.RDaddr_i   = rd;   if_n.RDaddr_i   = rd;
  endtask

  task automatic drive_rd(input logic [4:0] rs, input logic [4:0] rt);
    if_b.RSaddr_i = rs; if_n.RSaddr_i = rs;
    if_b.RTaddr_i = rt; if_n.RTaddr_i = rt;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // read a register through port A of both instances after settling
  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    drive_rd(a, a);
    #1;
    check({tag, "_b_rs"}, if_b.RSdata_o, exp);
    check({tag, "_b_rt"}, if_b.RTdata_o, exp);
    check({tag, "_n_rs"}, if_n.RSdata_o, exp);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b1;
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd0, 5'd0);
    #1 rst_n = 1'b0;
    repeat (2) next_cycle();

    // reset state: every register reads zero, counter zero
    for (int a = 0; a < 32; a++) begin
      drive_rd(5'(a), 5'(31 - a));
      #1;
      check("rst_rs", if_b.RSdata_o, 32'h0);
      check("rst_rt", if_n.RTdata_o, 32'h0);
    end
    check("rst_cnt_b", if_b.WBcount_o, 32'h0);
    check("rst_cnt_n", if_n.WBcount_o, 32'h0);
    rst_n = 1'b1;
    next_cycle();

    // mux and commit: ALU path to x5, memory path to x6
    drive_wr(1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_1234, 5'd5);
    #1;
    check("mux_alu", if_b.WBdata_o, 32'h0000_1234);
    check("valid_5", {31'b0, if_b.WBvalid_o}, 32'h1);
    next_cycle();
    drive_wr(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_5555, 5'd6);
    #1;
    check("mux_mem", if_n.WBdata_o, 32'hDEAD_BEEF);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd5, 5'd6);
    #1;
    check("x5_rs", if_b.RSdata_o, 32'h0000_1234);
    check("x6_rt", if_b.RTdata_o, 32'hDEAD_BEEF);
    check("x5_rs_n", if_n.RSdata_o, 32'h0000_1234);
    check("x6_rt_n", if_n.RTdata_o, 32'hDEAD_BEEF);
    check("cnt_2", if_b.WBcount_o, 32'd2);

    // x0 write is dropped, not bypassed, not counted
    drive_wr(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    drive_rd(5'd0, 5'd0);
    #1;
    check("x0_valid", {31'b0, if_b.WBvalid_o}, 32'h0);
    check("x0_bypass", if_b.RSdata_o, 32'h0);
    check("x0_wbdata", if_b.WBdata_o, 32'hFFFF_FFFF);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("x0_after", if_b.RSdata_o, 32'h0);
    check("x0_cnt", if_b.WBcount_o, 32'd2);

    // same-cycle bypass: x7 holds 0x11, then write 0x22 while reading x7
    drive_wr(1'b1, 1'b0, 32'h0, 32'h11, 5'd7);
    next_cycle();
    drive_wr(1'b1, 1'b0, 32'h0, 32'h22, 5'd7);
    drive_rd(5'd7, 5'd7);
    #1;
    check("byp_b_rs", if_b.RSdata_o, 32'h22);
    check("byp_b_rt", if_b.RTdata_o, 32'h22);
    check("nobyp_rs", if_n.RSdata_o, 32'h11);
    check("nobyp_rt", if_n.RTdata_o, 32'h11);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check_reg("x7_after", 5'd7, 32'h22);
    check("cnt_4", if_n.WBcount_o, 32'd4);

    // one port bypasses, the other reads stored data
    drive_wr(1'b1, 1'b0, 32'h0, 32'h77, 5'd8);
    drive_rd(5'd8, 5'd5);
    #1;
    check("split_rs", if_b.RSdata_o, 32'h77);
    check("split_rt", if_b.RTdata_o, 32'h0000_1234);
    next_cycle();

    // write suppressed by RegWrite=0
    drive_wr(1'b0, 1'b0, 32'h0, 32'h55, 5'd9);
    drive_rd(5'd9, 5'd9);
    #1;
    check("sup_wbdata", if_b.WBdata_o, 32'h55);
    check("sup_valid", {31'b0, if_b.WBvalid_o}, 32'h0);
    check("sup_nobyp", if_b.RSdata_o, 32'h0);
    next_cycle();
    check_reg("sup_x9", 5'd9, 32'h0);
    check("sup_cnt", if_b.WBcount_o, 32'd5);

    // consecutive writes to the same register: last wins
    drive_wr(1'b1, 1'b0, 32'h0, 32'hA0A0_0001, 5'd10);
    next_cycle();
    drive_wr(1'b1, 1'b1, 32'hB0B0_0002, 32'h0, 5'd10);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check_reg("last_wins", 5'd10, 32'hB0B0_0002);
    check("cnt_7", if_b.WBcount_o, 32'd7);

    // reset racing a write to x3; bypass stays live during reset
    drive_wr(1'b1, 1'b0, 32'h0, 32'h33, 5'd3);
    drive_rd(5'd3, 5'd5);
    rst_n = 1'b0;
    #1;
    check("rst_byp_b", if_b.RSdata_o, 32'h33);
    check("rst_nobyp_n", if_n.RSdata_o, 32'h0);
    check("rst_clr_x5", if_b.RTdata_o, 32'h0);
    check("rst_cnt", if_b.WBcount_o, 32'h0);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    check_reg("race_x3", 5'd3, 32'h0);
    check_reg("race_x10", 5'd10, 32'h0);
    check("race_cnt", if_n.WBcount_o, 32'h0);

    // first commit after reset
    drive_wr(1'b1, 1'b0, 32'h0, 32'h44, 5'd3);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check_reg("post_rst_x3", 5'd3, 32'h44);
    check("post_rst_cnt", if_b.WBcount_o, 32'd1);

    // counter wrap: preload all-ones, then one commit
    force dut_b.wbcount_q = 32'hFFFF_FFFF;
    #1;
    release dut_b.wbcount_q;
    drive_wr(1'b1, 1'b0, 32'h0, 32'h66, 5'd4);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("wrap_cnt", if_b.WBcount_o, 32'h0);
    check("nowrap_cnt", if_n.WBcount_o, 32'd2);
    drive_wr(1'b1, 1'b0, 32'h0, 32'h67, 5'd4);
    next_cycle();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("wrap_cnt_1", if_b.WBcount_o, 32'd1);
    check_reg("wrap_x4", 5'd4, 32'h67);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. It selects the writeback value (memory data or ALU result) and commits it to a 32-entry general-purpose register file. It serves the two ID-stage read ports, with same-cycle write-to-read bypass. It also exposes the selected writeback value to the forwarding unit and keeps a count of committed register writes.

Parameters:
DATA_W  32  register and datapath width in bits
NREG  32  number of architectural registers; must equal 2**ADDR_W
ADDR_W  5  register address width
BYPASS  1  1 = a read of the register being written this cycle returns the new value; 0 = it returns the stored old value

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-low (0 = reset)
RegWrite_i  input  1  writeback enable, from MEM/WB RegWrite_o
MemtoReg_i  input  1  1 = write Data_i, 0 = write ALUout_i; from MEM/WB MemtoReg_o
Data_i  input  DATA_W  memory read data, from MEM/WB Data_o
ALUout_i  input  DATA_W  ALU result, from MEM/WB ALUout_o
RDaddr_i  input  ADDR_W  destination register, from MEM/WB RDaddr_o
RSaddr_i  input  ADDR_W  read port A address (ID stage)
RTaddr_i  input  ADDR_W  read port B address (ID stage)
RSdata_o  output  DATA_W  read port A data
RTdata_o  output  DATA_W  read port B data
WBdata_o  output  DATA_W  selected writeback value, to forwarding unit
WBvalid_o  output  1  RegWrite_i AND (RDaddr_i != 0), to forwarding unit
WBcount_o  output  32  number of committed writes since reset

Behaviour:
- Writeback value: WBdata_o = MemtoReg_i ? Data_i : ALUout_i. Purely combinational; meaningful even when RegWrite_i = 0.
- Commit condition: WBvalid_o = RegWrite_i && RDaddr_i != 0.
- On each rising edge with WBvalid_o = 1: reg[RDaddr_i] <= WBdata_o. Commit latency is one edge.
- Register 0:
  - Hardwired zero; never written.
  - Reads of address 0 always return 0, including under bypass.
  - A write to address 0 is dropped and is not counted.
- Reads are combinational and asynchronous with respect to address: RSdata_o depends on RSaddr_i, RTdata_o on RTaddr_i.
- Bypass (BYPASS = 1): if WBvalid_o = 1 and RSaddr_i == RDaddr_i, then RSdata_o = WBdata_o in the same cycle. Same rule for RTaddr_i and RTdata_o. Both ports may bypass at once.
- Bypass disabled (BYPASS = 0): reads return stored contents. The new value appears on the cycle after the commit edge.
- WBcount_o:
  - Increments by 1 on each edge with WBvalid_o = 1.
  - Wraps from 0xFFFFFFFF to 0 with no sticky flag.
  - Held when WBvalid_o = 0.
- Reset (rst_i = 0):
  - Asynchronously clears all registers 1..NREG-1 and WBcount_o to 0.
  - Reset dominates any coincident write; no write commits on an edge where rst_i = 0.
  - While rst_i = 0, RSdata_o and RTdata_o read 0, except via bypass: bypass remains combinational and is not suppressed by reset.
- Reset mid-operation: an in-flight writeback value is lost. The first commit after reset occurs on the first rising edge with rst_i = 1 and WBvalid_o = 1.
- Consecutive writes to the same register: the last write wins. A read in the cycle after a write returns that write's value.
- X-propagation: an X on RegWrite_i must not corrupt registers not addressed by RDaddr_i.
- No stall or flush inputs: upstream suppresses writes by deasserting RegWrite_i.

Test Plan:
- Reset then read all: assert rst_i = 0 mid-run, release, sweep RSaddr_i/RTaddr_i over 0..31 -> all reads 0, WBcount_o = 0.
- Mux and commit: RegWrite=1, MemtoReg=0, ALUout=0x0000_1234, RD=5, then MemtoReg=1, Data=0xDEAD_BEEF, RD=6 -> next cycle reg5 = 0x1234, reg6 = 0xDEADBEEF, WBcount_o = 2.
- x0 write: RegWrite=1, RD=0, ALUout=0xFFFF_FFFF -> RSdata_o(addr 0) = 0, WBvalid_o = 0, WBcount_o unchanged.
- Same-cycle bypass: reg7 holds 0x11; drive write 0x22 to RD=7 with RS=RT=7 -> both outputs 0x22 before the edge with BYPASS=1, and 0x11 with BYPASS=0; after the edge both read 0x22.
- Write suppressed: RegWrite=0, RD=9, ALUout=0x55 -> reg9 unchanged, WBdata_o = 0x55, count unchanged.
- Counter wrap and reset race: force 2^32-1 commits, or preload via a bench hook, then one more -> WBcount_o = 0. Assert rst_i low coincident with a write to reg3 -> reg3 = 0 after release.
